// File: rtl/stall_ctrl.sv
// Central pipeline stall scheduler: merges ID/EX/MEM stall requests into the shared
// stop bus and sequences multi-cycle multiply/divide occupancy in EX.
module stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       id_load_use,
    input  logic       ex_div_start,
    input  logic       ex_mul_start,
    input  logic       mem_wait,
    output logic [5:0] stall,
    output logic       ex_busy,
    output logic       ex_op_done
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // Stops are contiguous from PC so the bubble lands right after the deepest stopped stage.
    localparam logic [5:0] StallMem  = 6'b011111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] DivLoad   = 6'(DIV_CYCLES - 1);
    localparam logic [5:0] MulLoad   = 6'(MUL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       ex_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ex_div_start) begin
                        state_d = StBusy;
                        cnt_d   = DivLoad;
                    end else if (ex_mul_start) begin
                        state_d = StBusy;
                        cnt_d   = MulLoad;
                    end
                end
                StBusy: begin
                    // Counts through MEM stalls; leaving at 1 means cnt never wraps.
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    // Hold the result-valid until EX is actually allowed to advance.
                    if (!stall[3]) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        stall      = '0;
        ex_busy    = 1'b0;
        ex_op_done = 1'b0;
        ex_req     = ((state_q == StIdle) && (ex_div_start || ex_mul_start))
                     || (state_q == StBusy);
        if (resetn) begin
            ex_busy = (state_q == StBusy);
            if (!flush) begin
                ex_op_done = (state_q == StDone);
                if (mem_wait) begin
                    stall = StallMem;
                end else if (ex_req) begin
                    stall = StallEx;
                end else if (id_load_use) begin
                    stall = StallId;
                end
            end
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: a time-based reference model (start cycle plus op
// length) predicts the stall bus, busy and done flags every cycle.
module tb_stall_ctrl;

    localparam int DIV = 33;
    localparam int MUL = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       flush = 1'b0;
    logic       id_load_use = 1'b0;
    logic       ex_div_start = 1'b0;
    logic       ex_mul_start = 1'b0;
    logic       mem_wait = 1'b0;
    logic [5:0] stall;
    logic       ex_busy;
    logic       ex_op_done;

    int total = 0;
    int bad = 0;

    // Model: an op occupies EX from its start cycle t0 for len cycles, then waits for EX to
    // advance (no MEM stall) before EX is free again.
    int cyc = 0;
    bit m_active = 0;
    int m_t0 = 0;
    int m_len = 0;

    stall_ctrl #(
        .DIV_CYCLES(DIV),
        .MUL_CYCLES(MUL)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .id_load_use (id_load_use),
        .ex_div_start(ex_div_start),
        .ex_mul_start(ex_mul_start),
        .mem_wait    (mem_wait),
        .stall       (stall),
        .ex_busy     (ex_busy),
        .ex_op_done  (ex_op_done)
    );

    always #5 clk = ~clk;

    // 0 = free, 1 = occupying EX, 2 = result ready
    function automatic int phase();
        if (!m_active) return 0;
        if (cyc < m_t0 + m_len) return 1;
        return 2;
    endfunction

    function automatic logic [7:0] exp_out();
        int ph;
        bit ex_req;
        logic [5:0] s;
        if (!resetn) return 8'h00;
        ph = phase();
        if (flush) return {6'b0, ph == 1, 1'b0};
        ex_req = (ph == 0 && (ex_div_start || ex_mul_start)) || ph == 1;
        if (mem_wait) s = 6'b011111;
        else if (ex_req) s = 6'b001111;
        else if (id_load_use) s = 6'b000111;
        else s = 6'b000000;
        return {s, ph == 1, ph == 2};
    endfunction

    task automatic drive(input bit fl, input bit li, input bit ds, input bit ms, input bit mw);
        flush = fl;
        id_load_use = li;
        ex_div_start = ds;
        ex_mul_start = ms;
        mem_wait = mw;
        #3;
    endtask

    task automatic tick();
        int ph;
        ph = phase();
        if (!resetn || flush) begin
            m_active = 0;
        end else if (ph == 0 && (ex_div_start || ex_mul_start)) begin
            m_active = 1;
            m_t0 = cyc;
            m_len = ex_div_start ? DIV : MUL;
        end else if (ph == 2 && !mem_wait) begin
            m_active = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
            e = exp_out();
            total++;
            if ({stall, ex_busy, ex_op_done} !== e) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", i, {stall, ex_busy, ex_op_done}, e);
            end
            tick();
        end
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0);
        total++;
        if ({stall, ex_busy, ex_op_done} !== 8'h00) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", {stall, ex_busy, ex_op_done}, 8'h00);
        end
        tick();
    endtask

    task automatic test_divide();
        logic [7:0] e;
        int t0, done_at, busy_n;
        t0 = cyc;
        done_at = -1;
        busy_n = 0;
        for (int i = 0; i < DIV + 4; i++) begin
            drive(0, $urandom_range(0, 1), i == 0, 0, 0);
            e = exp_out();
            total++;
            if ({stall, ex_busy, ex_op_done} !== e) begin
                bad++;
                $display("FAIL divide t=%0d got=%b want=%b", i, {stall, ex_busy, ex_op_done}, e);
            end
            if (ex_busy) busy_n++;
            if (ex_op_done && done_at < 0) done_at = cyc - t0;
            tick();
        end
        total++;
        if (done_at !== DIV) begin
            bad++;
            $display("FAIL divide_done_time got=%0d want=%0d", done_at, DIV);
        end
        total++;
        if (busy_n !== DIV - 1) begin
            bad++;
            $display("FAIL divide_busy_len got=%0d want=%0d", busy_n, DIV - 1);
        end
    endtask

    task automatic test_priority();
        logic [5:0] want;
        drive(0, 1, 0, 1, 0);
        tick();
        drive(0, 1, 0, 0, 1);
        total++;
        if (stall !== 6'b011111) begin
            bad++;
            $display("FAIL prio_mem got=%b want=%b", stall, 6'b011111);
        end
        tick();
        drive(0, 1, 0, 0, 0);
        total++;
        if (stall !== 6'b001111) begin
            bad++;
            $display("FAIL prio_ex got=%b want=%b", stall, 6'b001111);
        end
        tick();
        while (phase() == 1) begin
            drive(0, 1, 0, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0, 0);
        want = 6'b000111;
        total++;
        if ({stall, ex_op_done} !== {want, 1'b1}) begin
            bad++;
            $display("FAIL prio_id got=%b/%b want=%b/1", stall, ex_op_done, want);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_mem_wait_done();
        logic [7:0] e;
        int t0;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, i == 0, 0, (i >= 31 && i <= 36));
            e = exp_out();
            total++;
            if ({stall, ex_busy, ex_op_done} !== e) begin
                bad++;
                $display("FAIL memwait t=%0d got=%b want=%b", i, {stall, ex_busy, ex_op_done}, e);
            end
            if (i == 36) begin
                total++;
                if ({stall, ex_op_done} !== {6'b011111, 1'b1}) begin
                    bad++;
                    $display("FAIL memwait_hold got=%b/%b want=011111/1", stall, ex_op_done);
                end
            end
            tick();
        end
    endtask

    task automatic test_both_starts();
        logic [7:0] e;
        int t0, done_at;
        t0 = cyc;
        done_at = -1;
        for (int i = 0; i < DIV + 3; i++) begin
            drive(0, 0, i == 0 || i == 5, i == 0 || i == 9, 0);
            e = exp_out();
            total++;
            if ({stall, ex_busy, ex_op_done} !== e) begin
                bad++;
                $display("FAIL both t=%0d got=%b want=%b", i, {stall, ex_busy, ex_op_done}, e);
            end
            if (ex_op_done && done_at < 0) done_at = cyc - t0;
            tick();
        end
        total++;
        if (done_at !== DIV) begin
            bad++;
            $display("FAIL both_done_time got=%0d want=%0d", done_at, DIV);
        end
    endtask

    task automatic test_flush();
        logic [7:0] e;
        bit seen_done;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            drive(i == 5, 0, 0, i == 0, 0);
            e = exp_out();
            total++;
            if ({stall, ex_busy, ex_op_done} !== e) begin
                bad++;
                $display("FAIL flush t=%0d got=%b want=%b", i, {stall, ex_busy, ex_op_done}, e);
            end
            if (ex_op_done) seen_done = 1;
            tick();
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_done got=%b want=0", seen_done);
        end
    endtask

    task automatic test_reset_mid_div();
        drive(0, 0, 1, 0, 0);
        tick();
        for (int i = 1; i < 10; i++) begin
            drive(0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 1, 1, 1, 1);
        resetn = 1'b0;
        #1;
        total++;
        if ({stall, ex_busy, ex_op_done} !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid got=%b want=%b", {stall, ex_busy, ex_op_done}, 8'h00);
        end
        tick();
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0);
        total++;
        if ({stall, ex_busy, ex_op_done} !== 8'h00) begin
            bad++;
            $display("FAIL reset_after got=%b want=%b", {stall, ex_busy, ex_op_done}, 8'h00);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0);
            e = exp_out();
            total++;
            if ({stall, ex_busy, ex_op_done} !== e) begin
                bad++;
                $display("FAIL random i=%0d got=%b want=%b", i, {stall, ex_busy, ex_op_done}, e);
            end
            tick();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_divide();
        test_priority();
        test_mem_wait_done();
        test_both_starts();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
